// File: rtl/lbp_pkg.sv
// Shared constants for the LBP histogram block: frame geometry, bin sizing,
// FSM encoding and the interior-pixel test.
package lbp_pkg;

  localparam int NUM_BINS  = 256;
  localparam int BIN_W_DEF = 14;
  localparam int IMG_W     = 128;
  localparam int COORD_W   = $clog2(IMG_W);
  localparam int ADDR_W    = 2 * COORD_W;
  localparam int CODE_W    = $clog2(NUM_BINS);

  localparam logic [COORD_W-1:0] INT_LO = COORD_W'(1);
  localparam logic [COORD_W-1:0] INT_HI = COORD_W'(IMG_W - 2);

  localparam logic [1:0] ST_ACC      = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW = 2'd3;

  // Address is row-major: upper bits are the row, lower bits the column.
  function automatic logic is_interior(input logic [ADDR_W-1:0] addr);
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    row = addr[ADDR_W-1:COORD_W];
    col = addr[COORD_W-1:0];
    return (row >= INT_LO) && (row <= INT_HI) && (col >= INT_LO) && (col <= INT_HI);
  endfunction

endpackage

// File: rtl/lbp_hist_bank.sv
// Register bank of saturating bin counters with one increment port, one
// clear port and an asynchronous read mux.
module lbp_hist_bank
  import lbp_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_en,
  input  logic [CODE_W-1:0] inc_bin,
  input  logic              clr_en,
  input  logic [CODE_W-1:0] clr_bin,
  input  logic [CODE_W-1:0] rd_bin,
  output logic [BIN_W-1:0]  rd_data
);

  localparam logic [BIN_W-1:0] BIN_MAX = '1;

  logic [BIN_W-1:0] bin_q [NUM_BINS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BINS; gi++) begin : g_bin
      logic [BIN_W-1:0] count_reg;
      logic             hit_inc;
      logic             hit_clr;

      assign hit_inc = inc_en && (inc_bin == CODE_W'(gi));
      assign hit_clr = clr_en && (clr_bin == CODE_W'(gi));

      // Clear wins over increment; the FSM never asserts both, but this keeps a read bin empty.
      always_ff @(posedge clk) begin
        if (!reset) begin
          count_reg <= '0;
        end else if (hit_clr) begin
          count_reg <= '0;
        end else if (hit_inc && (count_reg != BIN_MAX)) begin
          count_reg <= count_reg + BIN_W'(1);
        end
      end

      assign bin_q[gi] = count_reg;
    end
  endgenerate

  assign rd_data = bin_q[rd_bin];

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates interior-pixel codes, then streams and
// clears all bins with valid/ready once the frame-complete level rises.
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [CODE_W-1:0] lbp_data,
  input  logic              finish,
  input  logic              hist_ready,
  output logic              hist_valid,
  output logic [CODE_W-1:0] hist_addr,
  output logic [BIN_W-1:0]  hist_data,
  output logic              hist_done
);

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              finish_reg;
  logic [CODE_W-1:0] index_reg;
  logic              finish_rise;
  logic              inc_en;
  logic              accept;
  logic [BIN_W-1:0]  rd_data;

  assign finish_rise = finish && !finish_reg;
  assign inc_en      = (state_reg == ST_ACC) && lbp_valid && is_interior(lbp_addr);
  assign accept      = (state_reg == ST_DRAIN) && hist_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACC:      if (finish_rise) state_next = ST_DRAIN;
      ST_DRAIN:    if (accept && (index_reg == CODE_W'(NUM_BINS - 1))) state_next = ST_DONE;
      ST_DONE:     state_next = ST_WAIT_LOW;
      // Holding here until finish drops keeps a held level from re-draining.
      ST_WAIT_LOW: if (!finish) state_next = ST_ACC;
      default:     state_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= ST_ACC;
      finish_reg <= 1'b0;
      index_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      finish_reg <= finish;
      if (accept) index_reg <= index_reg + CODE_W'(1);
    end
  end

  lbp_hist_bank #(
    .BIN_W (BIN_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (inc_en),
    .inc_bin (lbp_data),
    .clr_en  (accept),
    .clr_bin (index_reg),
    .rd_bin  (index_reg),
    .rd_data (rd_data)
  );

  assign hist_valid = (state_reg == ST_DRAIN);
  assign hist_addr  = index_reg;
  assign hist_data  = hist_valid ? rd_data : '0;
  assign hist_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: per-frame hand-computed bin tables checked
// against the drained stream.
module tb_lbp_hist;
  import lbp_pkg::*;

  localparam int BW = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [CODE_W-1:0] lbp_data;
  logic              finish;
  logic              hist_ready;
  logic              hist_valid;
  logic [CODE_W-1:0] hist_addr;
  logic [BW-1:0]     hist_data;
  logic              hist_done;

  int n_checks = 0;
  int n_errors = 0;
  int exp_bins [NUM_BINS];
  int sum;

  lbp_hist #(.BIN_W(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_ready (hist_ready),
    .hist_valid (hist_valid),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .hist_done  (hist_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NUM_BINS; i++) exp_bins[i] = 0;
  endtask

  task automatic strobe(input int addr, input int code);
    lbp_valid = 1'b1;
    lbp_addr  = ADDR_W'(addr);
    lbp_data  = CODE_W'(code);
    step();
    lbp_valid = 1'b0;
  endtask

  // Called at the first DRAIN cycle; ends one cycle into WAIT_LOW.
  task automatic drain(input string name, input int toggle, input int noise, output int total);
    int  idx;
    int  cyc;
    logic rdy;
    idx   = 0;
    cyc   = 0;
    total = 0;
    if (noise != 0) begin
      lbp_valid = 1'b1;
      lbp_addr  = ADDR_W'(129);
      lbp_data  = 8'hFF;
    end
    while (idx < NUM_BINS && cyc < 1100) begin
      rdy = (toggle != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      hist_ready = rdy;
      check({name, "_valid"}, int'(hist_valid), 1);
      check({name, "_addr"}, int'(hist_addr), idx);
      check({name, "_data"}, int'(hist_data), exp_bins[idx]);
      if (rdy) total += int'(hist_data);
      step();
      cyc++;
      if (rdy) idx++;
    end
    check({name, "_bins_drained"}, idx, NUM_BINS);
    check({name, "_drain_cycles"}, cyc, (toggle != 0) ? 512 : 256);
    check({name, "_done_pulse"}, int'(hist_done), 1);
    check({name, "_done_valid"}, int'(hist_valid), 0);
    step();
    check({name, "_done_width"}, int'(hist_done), 0);
    check({name, "_wait_valid"}, int'(hist_valid), 0);
    $display("frame %s: drained %0d bins in %0d cycles, sum %0d", name, idx, cyc, total);
  endtask

  task automatic end_frame();
    finish = 1'b0;
    step();
    lbp_valid = 1'b0;
    step();
  endtask

  initial begin
    int bad;
    reset      = 1'b0;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", int'(hist_valid), 0);
    check("rst_addr", int'(hist_addr), 0);
    check("rst_data", int'(hist_data), 0);
    check("rst_done", int'(hist_done), 0);
    reset = 1'b1;

    // Back-to-back 0x00,0x00,0xFF at interior pixels.
    clear_exp();
    exp_bins[0]   = 2;
    exp_bins[255] = 1;
    strobe(129, 8'h00);
    strobe(130, 8'h00);
    strobe(131, 8'hFF);
    finish = 1'b1;
    step();
    drain("basic", 0, 0, sum);
    check("basic_sum", sum, 3);
    // finish stays high: no second drain may start.
    bad = 0;
    repeat (8) begin
      if (hist_valid || hist_done) bad++;
      step();
    end
    check("held_finish_no_redrain", bad, 0);
    end_frame();

    // Border pixels dropped; strobe on the finish edge still counts; drain-time strobes ignored.
    clear_exp();
    exp_bins[16] = 1;
    strobe(0, 5);
    strobe(127, 5);
    strobe(128, 5);
    strobe(255, 5);
    strobe(127 * 128, 5);
    strobe(127 * 128 + 1, 5);
    lbp_valid = 1'b1;
    lbp_addr  = ADDR_W'(126 * 128 + 126);
    lbp_data  = 8'h10;
    finish    = 1'b1;
    step();
    lbp_valid = 1'b0;
    drain("border", 0, 1, sum);
    check("border_sum", sum, 1);
    end_frame();

    // Stalling consumer with ready pattern 1,0,0,1.
    clear_exp();
    exp_bins[1]   = 1;
    exp_bins[2]   = 2;
    exp_bins[254] = 3;
    strobe(200, 1);
    strobe(201, 2);
    strobe(202, 2);
    strobe(203, 254);
    strobe(204, 254);
    strobe(205, 254);
    finish = 1'b1;
    step();
    drain("stall", 1, 0, sum);
    check("stall_sum", sum, 6);
    end_frame();

    // Saturation: 16390 hits on one bin stop at 16383.
    clear_exp();
    exp_bins[8'h33] = 16383;
    for (int i = 0; i < 16390; i++) strobe(300, 8'h33);
    finish = 1'b1;
    step();
    drain("saturate", 0, 0, sum);
    end_frame();

    // Whole constant-gray frame: every code is 0xFF, only interior pixels count.
    clear_exp();
    exp_bins[255] = 15876;
    for (int a = 0; a < 16384; a++) strobe(a, 8'hFF);
    finish = 1'b1;
    step();
    drain("gray", 0, 0, sum);
    check("gray_sum", sum, 15876);
    end_frame();

    // Reset in the middle of a drain.
    strobe(400, 8'h80);
    strobe(401, 8'h80);
    strobe(402, 8'h80);
    strobe(403, 8'hFF);
    finish = 1'b1;
    step();
    hist_ready = 1'b1;
    for (int c = 0; c < 200 && int'(hist_addr) != 100; c++) step();
    check("abort_at_idx", int'(hist_addr), 100);
    check("abort_valid_before", int'(hist_valid), 1);
    reset  = 1'b0;
    finish = 1'b0;
    step();
    check("abort_valid", int'(hist_valid), 0);
    check("abort_addr", int'(hist_addr), 0);
    check("abort_data", int'(hist_data), 0);
    check("abort_done", int'(hist_done), 0);
    reset = 1'b1;
    strobe(500, 8'h80);
    bad = 0;
    repeat (20) begin
      if (hist_done || hist_valid) bad++;
      step();
    end
    check("abort_no_done", bad, 0);
    $display("frame abort: reset applied at drain index 100");
    clear_exp();
    exp_bins[8'h80] = 1;
    finish = 1'b1;
    step();
    drain("post_reset", 0, 0, sum);
    check("post_reset_sum", sum, 1);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
